// File: rtl/debug_counter_reader_pkg.sv
// Shared definitions for the debug counter readout: the frame FSM states,
// the frame constants and the snapshot byte selector.
package debug_counter_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } dbg_state_e;

    localparam logic [7:0] DBG_SYNC_BYTE  = 8'hA5;
    localparam int         DBG_NUM_CNT    = 5;
    localparam int         DBG_DATA_BYTES = 40;
    localparam int         DBG_FRAME_LEN  = 42;
    localparam int         DBG_SNAP_W     = DBG_NUM_CNT * 64;
    localparam logic [5:0] DBG_LAST_IDX   = 6'(DBG_DATA_BYTES - 1);

    // Byte 0 is the most significant byte of the snapshot, so walking idx
    // upward sends the first counter MSB first, then the next counter, etc.
    function automatic logic [7:0] snap_byte(input logic [DBG_SNAP_W-1:0] snap,
                                             input logic [5:0]            idx);
        logic [8:0] lsb;
        lsb = 9'(DBG_SNAP_W - 8) - {idx, 3'b000};
        return snap[lsb +: 8];
    endfunction

endpackage

// File: rtl/debug_counter_reader.sv
// Captures the five 64-bit debug counters on a snapshot request and streams
// them as a 42-byte frame: sync byte, 40 data bytes, XOR checksum.
//
// Byte handshake: a byte transfers on every rising edge where
// out_valid && out_ready. out_valid depends only on registered state, never
// on out_ready; while out_valid is high and out_ready low, out_data and the
// FSM state hold.
module debug_counter_reader
    import debug_counter_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snap_req,
    input  logic [63:0] counter,
    input  logic [63:0] buffer_invalid_counter,
    input  logic [63:0] residual_counter,
    input  logic [63:0] intra_pred_counter,
    input  logic [63:0] sum_pred_counter,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output dbg_state_e  fsm_state
);

    dbg_state_e            state;
    dbg_state_e            state_next;
    logic [DBG_SNAP_W-1:0] snapshot;
    logic [7:0]            xor_acc;
    logic [5:0]            byte_idx;
    logic [7:0]            data_byte;
    logic                  hs;

    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign hs        = out_valid && out_ready;
    assign data_byte = snap_byte(snapshot, byte_idx);

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (snap_req) state_next = SYNC;
            SYNC: if (hs) state_next = DATA;
            DATA: if (hs && byte_idx == DBG_LAST_IDX) state_next = CSUM;
            CSUM: if (hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Snapshot capture, running checksum, byte index and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot   <= '0;
            xor_acc    <= '0;
            byte_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == CSUM) && hs;
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        snapshot <= {counter, buffer_invalid_counter, residual_counter,
                                     intra_pred_counter, sum_pred_counter};
                        xor_acc  <= '0;
                        byte_idx <= '0;
                    end
                end
                DATA: begin
                    if (hs) begin
                        xor_acc <= xor_acc ^ data_byte;
                        // Index stops at the last byte so it never selects past the snapshot.
                        if (byte_idx != DBG_LAST_IDX) byte_idx <= byte_idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output byte mux, decoded from registered state, index and checksum.
    always_comb begin
        out_data = 8'h00;
        case (state)
            SYNC:    out_data = DBG_SYNC_BYTE;
            DATA:    out_data = data_byte;
            CSUM:    out_data = xor_acc;
            default: out_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_debug_counter_reader.sv
// Directed bench for debug_counter_reader: reset, basic frame, backpressure,
// snapshot isolation, ignored request, back-to-back frames and mid-frame abort.
module tb_debug_counter_reader;
    import debug_counter_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snap_req;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    dbg_state_e  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int snap_cyc = 0;

    logic       stalled = 1'b0;
    logic [7:0] hold_data = 8'h00;
    dbg_state_e hold_state = IDLE;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    debug_counter_reader dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .snap_req               (snap_req),
        .counter                (c0),
        .buffer_invalid_counter (c1),
        .residual_counter       (c2),
        .intra_pred_counter     (c3),
        .sum_pred_counter       (c4),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .busy                   (busy),
        .frame_done             (frame_done),
        .fsm_state              (fsm_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: clears snap_req, records accepted bytes and done pulses,
    // checks hold-stability under backpressure, picks out_ready for the next edge.
    task automatic step(input int pct);
        logic rdy;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) begin
            if (stalled) begin
                check("stable_data", out_data, hold_data);
                check("stable_state", fsm_state, hold_state);
            end
            rdy = ($urandom_range(99) < pct);
            if (rdy) got_q.push_back(out_data);
            stalled    = !rdy;
            hold_data  = out_data;
            hold_state = fsm_state;
        end else begin
            rdy     = 1'b1;
            stalled = 1'b0;
        end
        out_ready = rdy;
    endtask

    task automatic run_until_done(input int pct, input int max_cyc);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max_cyc) begin
            step(pct);
            n++;
        end
        check("done_seen", (done_cnt != start), 1);
    endtask

    task automatic build_exp(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2,
                             input logic [63:0] v3, input logic [63:0] v4);
        logic [63:0] v[5];
        logic [7:0]  x;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3; v[4] = v4;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        for (int k = 0; k < 5; k++) begin
            for (int b = 7; b >= 0; b--) begin
                exp_q.push_back(v[k][b*8 +: 8]);
                x = x ^ v[k][b*8 +: 8];
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_byte"}, got_q[i], exp_q[i]);
            else                  check({tag, "_missing"}, 8'hxx, exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_data"}, out_data, 8'h00);
        check({tag, "_state"}, fsm_state, IDLE);
    endtask

    initial begin
        int start_done;
        int fl;
        bit pulsed;

        rst_n = 1'b0;
        snap_req = 1'b0;
        out_ready = 1'b1;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0; c4 = '0;
        fl = DBG_FRAME_LEN;

        // Reset state
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(100);
        check_reset_outputs("idle_after_reset");

        // Basic frame with out_ready held high
        c0 = 64'h0102030405060708;
        build_exp(c0, 64'h0, 64'h0, 64'h0, 64'h0);
        got_q.delete();
        snap_req = 1'b1;
        snap_cyc = cyc;
        run_until_done(100, 60);
        compare_frame("basic");
        check("basic_frame_len", got_q.size(), fl);
        if (got_q.size() == 42) begin
            check("basic_sync", got_q[0], 8'hA5);
            check("basic_first", got_q[1], 8'h01);
            check("basic_eighth", got_q[8], 8'h08);
            check("basic_zero", got_q[9], 8'h00);
            check("basic_csum", got_q[41], 8'h08);
        end
        check("basic_done_latency", done_cyc - snap_cyc, 43);
        check("basic_busy_at_done", busy, 0);
        check("basic_done_cnt", done_cnt, 1);

        // Same stimulus under random backpressure
        step(100);
        step(100);
        got_q.delete();
        snap_req = 1'b1;
        run_until_done(50, 400);
        compare_frame("bp");

        // Inputs change one cycle after capture
        c0 = 64'h1122334455667788;
        c1 = 64'h0F1E2D3C4B5A6978;
        c2 = 64'hDEADBEEF00C0FFEE;
        c3 = 64'h8000000000000001;
        c4 = 64'h0123456789ABCDEF;
        build_exp(c0, c1, c2, c3, c4);
        step(100);
        got_q.delete();
        snap_req = 1'b1;
        step(100);
        c0 = '1; c1 = '1; c2 = '1; c3 = '1; c4 = '1;
        run_until_done(100, 60);
        compare_frame("iso");

        // snap_req during byte 10 is ignored
        c0 = 64'hA1A2A3A4A5A6A7A8;
        c1 = 64'h0; c2 = 64'h0; c3 = 64'h0;
        c4 = 64'h00000000000000FF;
        build_exp(c0, c1, c2, c3, c4);
        step(100);
        got_q.delete();
        start_done = done_cnt;
        pulsed = 1'b0;
        snap_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(100);
            if (got_q.size() == 10 && !pulsed) begin
                snap_req = 1'b1;
                pulsed = 1'b1;
            end
        end
        check("ign_pulsed", pulsed, 1);
        check("ign_done_cnt", done_cnt - start_done, 1);
        compare_frame("ign");
        check("ign_idle", busy, 0);

        // Back-to-back: request in the frame_done cycle
        got_q.delete();
        snap_req = 1'b1;
        run_until_done(100, 60);
        compare_frame("b2b_first");
        check("b2b_done_state", fsm_state, IDLE);
        got_q.delete();
        snap_req = 1'b1;
        step(100);
        check("b2b_sync_valid", out_valid, 1);
        check("b2b_sync_data", out_data, 8'hA5);
        run_until_done(100, 60);
        compare_frame("b2b_second");

        // Abort with reset at byte 20, then a clean frame
        c0 = 64'h5555AAAA5555AAAA;
        c1 = 64'h1234000000005678;
        c2 = 64'h0;
        c3 = 64'hFEDCBA9876543210;
        c4 = 64'h0000000100000002;
        build_exp(c0, c1, c2, c3, c4);
        step(100);
        got_q.delete();
        snap_req = 1'b1;
        for (int i = 0; i < 100 && got_q.size() < 20; i++) step(100);
        check("abort_reached_20", got_q.size(), 20);
        start_done = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        step(100);
        step(100);
        rst_n = 1'b1;
        repeat (3) step(100);
        check("abort_no_more_bytes", got_q.size(), 20);
        check("abort_no_done", done_cnt, start_done);
        check("abort_idle", out_valid, 0);
        got_q.delete();
        snap_req = 1'b1;
        run_until_done(100, 60);
        compare_frame("after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
